// File: rtl/shake_arbiter.sv
// Round-robin arbiter sharing one SHAKE core among N_REQ requesters: one job owns the core from grant to last squeeze word.
// Optional macro SHAKE_ARB_PRIO0_EN gives requester 0 absolute priority in every idle arbitration.
module shake_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [2*N_REQ-1:0]   req_mode,
    input  logic [32*N_REQ-1:0]  req_output_size,
    input  logic [W*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_data_valid,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_data_ready,
    output logic [N_REQ-1:0]     grant,
    output logic                 core_start,
    output logic [1:0]           core_mode,
    output logic [31:0]          core_output_size,
    output logic [W-1:0]         core_data,
    output logic                 core_data_valid,
    output logic                 core_last,
    input  logic                 core_data_ready,
    input  logic [W-1:0]         core_data_out,
    input  logic                 core_valid_out,
    output logic                 core_ready_in,
    output logic [W-1:0]         rsp_data,
    output logic [N_REQ-1:0]     rsp_valid,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic                 busy
);

    localparam int LOG2W = $clog2(W);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [N_REQ-1:0] MASK_REQ0 = {{(N_REQ-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_ABSORB, ST_SQUEEZE} state_t;

    state_t            state_r, state_next_s;
    logic [N_REQ-1:0]  grant_r, grant_next_s;
    logic [2:0]        owner_r, owner_next_s;
    logic [2:0]        ptr_r, ptr_next_s;
    logic [31:0]       wcnt_r, wcnt_next_s;
    logic [1:0]        mode_r, mode_next_s;
    logic [31:0]       size_r, size_next_s;
    logic [3:0]        arb_s;
    int                owner_i_s;
    int                arb_i_s;

    // Lowest requester index at or after p, wrapping; result is {found, index}.
    function automatic logic [3:0] rr_pick(input logic [N_REQ-1:0] v, input logic [2:0] p);
        logic       found;
        logic [2:0] sel;
        int         idx;
        found = 1'b0;
        sel   = 3'd0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(p) + k) % N_REQ;
            if (!found && v[idx]) begin
                found = 1'b1;
                sel   = 3'(idx);
            end else begin
                found = found;
            end
        end
        return {found, sel};
    endfunction

    // Squeeze word count: 33-bit sum so a size of 0xFFFFFFFF cannot wrap; zero words still yields one.
    function automatic logic [31:0] words_for(input logic [31:0] size);
        logic [32:0] sum;
        logic [32:0] q;
        sum = {1'b0, size} + 33'(W - 1);
        q   = sum >> LOG2W;
        if (q[31:0] == 32'd0) begin
            return 32'd1;
        end else begin
            return q[31:0];
        end
    endfunction

    assign owner_i_s = int'(owner_r);
    assign arb_i_s   = int'(arb_s[2:0]);

    // Idle arbitration choice.
    always_comb begin
        arb_s = 4'd0;
`ifdef SHAKE_ARB_PRIO0_EN
        if (req_valid[0]) begin
            arb_s = {1'b1, 3'd0};
        end else begin
            arb_s = rr_pick(req_valid & MASK_REQ0, ptr_r);
        end
`else
        arb_s = rr_pick(req_valid, ptr_r);
`endif
    end

    // Next-state and next-register values of the job FSM.
    always_comb begin
        state_next_s = state_r;
        grant_next_s = grant_r;
        owner_next_s = owner_r;
        ptr_next_s   = ptr_r;
        wcnt_next_s  = wcnt_r;
        mode_next_s  = mode_r;
        size_next_s  = size_r;
        case (state_r)
            ST_IDLE: begin
                if (arb_s[3]) begin
                    state_next_s = ST_START;
                    owner_next_s = arb_s[2:0];
                    grant_next_s = ONE_HOT0 << arb_s[2:0];
                    mode_next_s  = req_mode[arb_i_s*2 +: 2];
                    size_next_s  = req_output_size[arb_i_s*32 +: 32];
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                wcnt_next_s  = words_for(size_r);
                state_next_s = ST_ABSORB;
            end
            ST_ABSORB: begin
                if (req_data_valid[owner_i_s] && core_data_ready && req_last[owner_i_s]) begin
                    state_next_s = ST_SQUEEZE;
                end else begin
                    state_next_s = ST_ABSORB;
                end
            end
            ST_SQUEEZE: begin
                if (core_valid_out && rsp_ready[owner_i_s]) begin
                    wcnt_next_s = wcnt_r - 32'd1;
                    if (wcnt_r == 32'd1) begin
                        state_next_s = ST_IDLE;
                        grant_next_s = {N_REQ{1'b0}};
                        ptr_next_s   = (owner_r == 3'(N_REQ - 1)) ? 3'd0 : owner_r + 3'd1;
                    end else begin
                        state_next_s = ST_SQUEEZE;
                    end
                end else begin
                    state_next_s = ST_SQUEEZE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                grant_next_s = {N_REQ{1'b0}};
            end
        endcase
    end

    // Job state registers; reset aborts any job in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            grant_r <= {N_REQ{1'b0}};
            owner_r <= 3'd0;
            ptr_r   <= 3'd0;
            wcnt_r  <= 32'd0;
            mode_r  <= 2'd0;
            size_r  <= 32'd0;
        end else begin
            state_r <= state_next_s;
            grant_r <= grant_next_s;
            owner_r <= owner_next_s;
            ptr_r   <= ptr_next_s;
            wcnt_r  <= wcnt_next_s;
            mode_r  <= mode_next_s;
            size_r  <= size_next_s;
        end
    end

    // Stream steering between the owner and the core; every non-owner lane stays quiet.
    always_comb begin
        req_data_ready  = {N_REQ{1'b0}};
        rsp_valid       = {N_REQ{1'b0}};
        core_data       = {W{1'b0}};
        core_data_valid = 1'b0;
        core_last       = 1'b0;
        core_ready_in   = 1'b0;
        rsp_data        = {W{1'b0}};
        case (state_r)
            ST_ABSORB: begin
                core_data                 = req_data[owner_i_s*W +: W];
                core_data_valid           = req_data_valid[owner_i_s];
                core_last                 = req_last[owner_i_s];
                req_data_ready[owner_i_s] = core_data_ready;
            end
            ST_SQUEEZE: begin
                rsp_data             = core_data_out;
                rsp_valid[owner_i_s] = core_valid_out;
                core_ready_in        = rsp_ready[owner_i_s];
            end
            default: begin
                core_ready_in = 1'b0;
            end
        endcase
    end

    assign grant            = grant_r;
    assign core_start       = (state_r == ST_START);
    assign busy             = (state_r != ST_IDLE);
    assign core_mode        = mode_r;
    assign core_output_size = size_r;

endmodule

// File: tb/tb_shake_arbiter.sv
// Directed self-checking bench for shake_arbiter (N_REQ=4, W=64); the core is played by the bench.
module tb_shake_arbiter;
    localparam int N = 4;
    localparam int W = 64;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] req_valid, req_data_valid, req_last, req_data_ready, grant, rsp_valid, rsp_ready;
    logic [2*N-1:0] req_mode;
    logic [32*N-1:0] req_output_size;
    logic [W*N-1:0] req_data;
    logic core_start, core_data_valid, core_last, core_data_ready, core_valid_out, core_ready_in, busy;
    logic [1:0] core_mode;
    logic [31:0] core_output_size;
    logic [W-1:0] core_data, core_data_out, rsp_data;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    shake_arbiter #(.N_REQ(N), .W(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_mode(req_mode), .req_output_size(req_output_size),
        .req_data(req_data), .req_data_valid(req_data_valid), .req_last(req_last),
        .req_data_ready(req_data_ready), .grant(grant), .core_start(core_start),
        .core_mode(core_mode), .core_output_size(core_output_size),
        .core_data(core_data), .core_data_valid(core_data_valid), .core_last(core_last),
        .core_data_ready(core_data_ready), .core_data_out(core_data_out),
        .core_valid_out(core_valid_out), .core_ready_in(core_ready_in),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .busy(busy)
    );

    task automatic clear_inputs();
        req_valid = '0; req_mode = '0; req_output_size = '0; req_data = '0;
        req_data_valid = '0; req_last = '0; core_data_ready = 1'b0;
        core_data_out = '0; core_valid_out = 1'b0; rsp_ready = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Runs one job with an always-ready core and consumers; reports grant, start pulses, words seen.
    task automatic run_one_job(output logic [3:0] g, output int starts, output int words, output bit tmo);
        g = '0; starts = 0; words = 0; tmo = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (busy) begin tmo = 1'b0; break; end
        end
        if (!tmo) begin
            g = grant;
            starts = core_start ? 1 : 0;
            tmo = 1'b1;
            for (int i = 0; i < 200; i++) begin
                if ((rsp_valid & g) != 4'b0000) words++;
                @(posedge clk); #1;
                if (!busy) begin tmo = 1'b0; break; end
                if (core_start) starts++;
            end
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        req_valid = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (grant !== 4'b0000) $display("FAIL rst_grant: got %b want 0000", grant); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passes++;
        checks++; if (core_start !== 1'b0) $display("FAIL rst_core_start: got %b want 0", core_start); else passes++;
        checks++; if (rsp_valid !== 4'b0000 || req_data_ready !== 4'b0000 || core_ready_in !== 1'b0)
            $display("FAIL rst_handshakes: got rsp_valid %b rdy %b cri %b want 0", rsp_valid, req_data_ready, core_ready_in); else passes++;
        checks++; if (dut.ptr_r !== 3'd0 || dut.wcnt_r !== 32'd0)
            $display("FAIL rst_ptr_wcnt: got %0d/%0d want 0/0", dut.ptr_r, dut.wcnt_r); else passes++;
        clear_inputs();
        rst = 1'b1;
    endtask

    task automatic test_single_job();
        req_valid = 4'b0010;
        req_output_size[63:32] = 32'd256;
        req_data[127:64] = 64'hA1A1_0000_0000_0001;
        req_data_valid = 4'b0010;
        core_data_ready = 1'b1;
        rsp_ready = 4'b0010;
        @(posedge clk); #1;
        checks++; if (grant !== 4'b0010) $display("FAIL sj_grant: got %b want 0010", grant); else passes++;
        checks++; if (core_start !== 1'b1 || busy !== 1'b1) $display("FAIL sj_start: got start %b busy %b want 1 1", core_start, busy); else passes++;
        req_valid = 4'b0000;
        @(posedge clk); #2;
        checks++; if (core_start !== 1'b0) $display("FAIL sj_start_pulse: got %b want 0", core_start); else passes++;
        checks++; if (dut.wcnt_r !== 32'd4) $display("FAIL sj_wcnt: got %0d want 4", dut.wcnt_r); else passes++;
        checks++; if (core_data !== 64'hA1A1_0000_0000_0001 || core_data_valid !== 1'b1)
            $display("FAIL sj_absorb0: got %h v%b want a1a1000000000001 v1", core_data, core_data_valid); else passes++;
        checks++; if (req_data_ready !== 4'b0010) $display("FAIL sj_data_ready: got %b want 0010", req_data_ready); else passes++;
        checks++; if (core_mode !== 2'd0 || core_output_size !== 32'd256)
            $display("FAIL sj_cfg: got %0d %0d want 0 256", core_mode, core_output_size); else passes++;
        @(posedge clk); #1;
        req_data[127:64] = 64'hA1A1_0000_0000_0002;
        req_last = 4'b0010;
        #1;
        checks++; if (core_data !== 64'hA1A1_0000_0000_0002 || core_last !== 1'b1)
            $display("FAIL sj_absorb1: got %h last %b want a1a1000000000002 1", core_data, core_last); else passes++;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            core_valid_out = 1'b1;
            core_data_out = 64'h5000 + 64'(i);
            #1;
            checks++; if (rsp_valid !== 4'b0010 || rsp_data !== 64'h5000 + 64'(i) || core_ready_in !== 1'b1)
                $display("FAIL sj_squeeze%0d: got v%b d%h r%b want v0010 d%h r1", i, rsp_valid, rsp_data, core_ready_in, 64'h5000 + 64'(i)); else passes++;
        end
        @(posedge clk); #1;
        core_valid_out = 1'b0;
        checks++; if (busy !== 1'b0 || grant !== 4'b0000) $display("FAIL sj_end: got busy %b grant %b want 0 0000", busy, grant); else passes++;
        checks++; if (dut.ptr_r !== 3'd2) $display("FAIL sj_ptr: got %0d want 2", dut.ptr_r); else passes++;
        clear_inputs();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5];
        logic [3:0] g;
        int starts, words;
        bit tmo;
        apply_reset();
        req_output_size = {4{32'd64}};
        req_data_valid = 4'b1111; req_last = 4'b1111;
        core_data_ready = 1'b1; core_valid_out = 1'b1; rsp_ready = 4'b1111;
`ifdef SHAKE_ARB_PRIO0_EN
        req_valid = 4'b0101;
        for (int j = 0; j < 5; j++) exp_g[j] = 4'b0001;
`else
        req_valid = 4'b1111;
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
`endif
        for (int j = 0; j < 5; j++) begin
            run_one_job(g, starts, words, tmo);
            checks++; if (tmo) $display("FAIL rr_timeout%0d: got timeout want job end", j); else passes++;
            checks++; if (g !== exp_g[j]) $display("FAIL rr_grant%0d: got %b want %b", j, g, exp_g[j]); else passes++;
            checks++; if (starts != 1 || words != 1) $display("FAIL rr_job%0d: got starts %0d words %0d want 1 1", j, starts, words); else passes++;
        end
        clear_inputs();
    endtask

    task automatic test_size_zero();
        apply_reset();
        req_valid = 4'b1000;
        req_data_valid = 4'b1000; req_last = 4'b1000;
        core_data_ready = 1'b1; core_valid_out = 1'b1; rsp_ready = 4'b1000;
        @(posedge clk); #1;
        req_valid = 4'b0000;
        checks++; if (grant !== 4'b1000) $display("FAIL sz0_grant: got %b want 1000", grant); else passes++;
        @(posedge clk); #1;
        checks++; if (dut.wcnt_r !== 32'd1) $display("FAIL sz0_wcnt: got %0d want 1", dut.wcnt_r); else passes++;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 4'b1000) $display("FAIL sz0_rsp: got %b want 1000", rsp_valid); else passes++;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || grant !== 4'b0000) $display("FAIL sz0_end: got busy %b grant %b want 0 0000", busy, grant); else passes++;
        clear_inputs();
    endtask

    task automatic test_backpressure();
        int words;
        bit done;
        apply_reset();
        req_valid = 4'b0100;
        req_output_size[95:64] = 32'd128;
        req_data_valid = 4'b0100; req_last = 4'b0100;
        core_data_ready = 1'b1; core_valid_out = 1'b1; core_data_out = 64'hCAFE;
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            checks++; if (core_ready_in !== 1'b0 || rsp_valid !== 4'b0100 || dut.wcnt_r !== 32'd2)
                $display("FAIL bp_hold%0d: got cri %b v %b wcnt %0d want 0 0100 2", i, core_ready_in, rsp_valid, dut.wcnt_r); else passes++;
            @(posedge clk); #1;
        end
        rsp_ready = 4'b0100;
        #1;
        checks++; if (core_ready_in !== 1'b1 || rsp_data !== 64'hCAFE) $display("FAIL bp_release: got cri %b d %h want 1 cafe", core_ready_in, rsp_data); else passes++;
        words = 0; done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if ((rsp_valid & 4'b0100) != 4'b0000) words++;
            @(posedge clk); #1;
            if (!busy) begin done = 1'b1; break; end
        end
        checks++; if (!done || words != 2) $display("FAIL bp_words: got %0d done %b want 2 1", words, done); else passes++;
        checks++; if (dut.ptr_r !== 3'd3) $display("FAIL bp_ptr: got %0d want 3", dut.ptr_r); else passes++;
        clear_inputs();
    endtask

    task automatic test_abort_mid_absorb();
        req_valid = 4'b0010;
        req_output_size[63:32] = 32'hFFFF_FFFF;
        req_mode[3:2] = 2'b11;
        req_data_valid = 4'b0010;
        core_data_ready = 1'b1; rsp_ready = 4'b0010;
        @(posedge clk); #1;
        req_valid = 4'b0000;
        checks++; if (grant !== 4'b0010) $display("FAIL ab_grant: got %b want 0010", grant); else passes++;
        @(posedge clk); #1;
        checks++; if (dut.wcnt_r !== 32'h0400_0000) $display("FAIL ab_wcnt: got %h want 04000000", dut.wcnt_r); else passes++;
        checks++; if (core_mode !== 2'b11 || core_output_size !== 32'hFFFF_FFFF)
            $display("FAIL ab_cfg: got %0d %h want 3 ffffffff", core_mode, core_output_size); else passes++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (core_data_valid !== 1'b1 || busy !== 1'b1) $display("FAIL ab_word3: got v %b busy %b want 1 1", core_data_valid, busy); else passes++;
        rst = 1'b0;
        #1;
        checks++; if (grant !== 4'b0000 || busy !== 1'b0 || core_start !== 1'b0)
            $display("FAIL ab_rst_ctrl: got g %b busy %b st %b want 0000 0 0", grant, busy, core_start); else passes++;
        checks++; if (req_data_ready !== 4'b0000 || core_data_valid !== 1'b0 || rsp_valid !== 4'b0000 || core_ready_in !== 1'b0)
            $display("FAIL ab_rst_streams: got rdy %b cv %b rv %b cri %b want 0", req_data_ready, core_data_valid, rsp_valid, core_ready_in); else passes++;
        clear_inputs();
        core_valid_out = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (dut.ptr_r !== 3'd0 || dut.wcnt_r !== 32'd0) $display("FAIL ab_ptr: got %0d wcnt %0d want 0 0", dut.ptr_r, dut.wcnt_r); else passes++;
        checks++; if (busy !== 1'b0 || rsp_valid !== 4'b0000) $display("FAIL ab_after: got busy %b rv %b want 0 0000", busy, rsp_valid); else passes++;
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_round_robin();
        test_size_zero();
        test_backpressure();
        test_abort_mid_absorb();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
